// File: rtl/ysyx_22041211_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041211_pc_ctrl
// Brief    : PC register and instruction-fetch sequencer with redirect/trap
//            kill handling and ebreak halt.
// Revision : 1.0
// ============================================================================
module ysyx_22041211_pc_ctrl #(
    parameter int                  ADDR_LEN  = 32,
    parameter logic [ADDR_LEN-1:0] RESET_VAL = ADDR_LEN'(32'h80000000)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                req_valid,
    output logic [ADDR_LEN-1:0] req_addr,
    input  logic                req_ready,
    input  logic                rsp_valid,
    input  logic [31:0]         rsp_inst,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    input  logic                inst_ready,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    input  logic                trap_valid,
    input  logic [ADDR_LEN-1:0] mtvec,
    input  logic                halt,
    output logic                halted,
    output logic [ADDR_LEN-1:0] pc
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_hold = 3'd3;
    localparam logic [2:0] c_st_halt = 3'd4;

    logic [2:0]          r_state;
    logic [ADDR_LEN-1:0] r_pc;
    logic [ADDR_LEN-1:0] r_req_addr;
    logic [31:0]         r_inst;
    logic [ADDR_LEN-1:0] r_inst_pc;
    logic                r_kill;
    logic                r_halt_pend;

    logic [2:0]          w_state_nxt;
    logic [ADDR_LEN-1:0] w_pc_nxt;
    logic                w_kill_nxt;
    logic                w_halt_nxt;
    logic                w_cap;
    logic                w_redir;
    logic [ADDR_LEN-1:0] w_tgt_raw;
    logic [ADDR_LEN-1:0] w_tgt;
    logic [ADDR_LEN-1:0] w_pc_seq;

    assign w_redir   = trap_valid | redirect_valid;
    assign w_tgt_raw = trap_valid ? mtvec : redirect_pc;
    assign w_tgt     = {w_tgt_raw[ADDR_LEN-1:2], 2'b00};
    assign w_pc_seq  = r_pc + ADDR_LEN'(4);

    // r_kill doubles as "pc already retargeted" while an instruction is held,
    // so the later consume must not add 4 on top of the new target.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_halt_nxt  = r_halt_pend | halt;
        w_cap       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_redir) w_pc_nxt = w_tgt;
                w_state_nxt = w_halt_nxt ? c_st_halt : c_st_req;
            end
            c_st_req: begin
                if (w_redir) begin
                    w_pc_nxt   = w_tgt;
                    w_kill_nxt = 1'b1;
                end
                if (req_ready) w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (w_redir) begin
                    w_pc_nxt   = w_tgt;
                    w_kill_nxt = 1'b1;
                end
                if (rsp_valid) begin
                    if (w_redir || r_kill || w_halt_nxt) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = w_halt_nxt ? c_st_halt : c_st_req;
                    end else begin
                        w_cap       = 1'b1;
                        w_state_nxt = c_st_hold;
                    end
                end
            end
            c_st_hold: begin
                if (w_redir) w_pc_nxt = w_tgt;
                if (inst_ready) begin
                    if (!w_redir && !r_kill) w_pc_nxt = w_pc_seq;
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = w_halt_nxt ? c_st_halt : c_st_req;
                end else if (w_redir) begin
                    w_kill_nxt = 1'b1;
                end
            end
            c_st_halt: begin
                w_state_nxt = c_st_halt;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_pc        <= RESET_VAL;
            r_req_addr  <= RESET_VAL;
            r_inst      <= '0;
            r_inst_pc   <= '0;
            r_kill      <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_kill      <= w_kill_nxt;
            r_halt_pend <= w_halt_nxt;
            if (w_cap) begin
                r_inst    <= rsp_inst;
                r_inst_pc <= r_pc;
            end
            // Request address is frozen for the whole time req_valid is high.
            if (w_state_nxt == c_st_req && r_state != c_st_req) begin
                r_req_addr <= w_pc_nxt;
            end
        end
    end

    assign req_valid  = (r_state == c_st_req);
    assign req_addr   = r_req_addr;
    assign inst_valid = (r_state == c_st_hold);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign halted     = (r_state == c_st_halt);
    assign pc         = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041211_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041211_pc_ctrl
// Brief    : Directed self-checking bench for the PC/fetch controller.
// Revision : 1.0
// ============================================================================
module tb_ysyx_22041211_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] mtvec;
    logic        halt;
    logic        halted;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    ysyx_22041211_pc_ctrl #(
        .ADDR_LEN  (32),
        .RESET_VAL (32'h80000000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_inst       (rsp_inst),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .mtvec          (mtvec),
        .halt           (halt),
        .halted         (halted),
        .pc             (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_ready = 0; rsp_valid = 0; rsp_inst = 0; inst_ready = 0;
        redirect_valid = 0; redirect_pc = 0; trap_valid = 0; mtvec = 0; halt = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        clear_inputs();
        cyc();
        cyc();
        rst = 1;
    endtask

    // Handshake one request and return a response; leaves the DUT in HOLD.
    task automatic fetch_to_hold(input logic [31:0] data);
        req_ready = 1; cyc(); req_ready = 0;
        rsp_valid = 1; rsp_inst = data; cyc(); rsp_valid = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        rsp_valid = 1;
        cyc();
        cyc();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", req_valid); end
        checks++; if (req_addr !== 32'h80000000) begin errors++; $display("FAIL rst_req_addr: got %h expected 80000000", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (pc !== 32'h80000000) begin errors++; $display("FAIL rst_pc: got %h expected 80000000", pc); end
        rsp_valid = 0;
        rst = 1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid: got %b expected 0", req_valid); end
        cyc();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h80000000) begin errors++; $display("FAIL first_req_addr: got %h expected 80000000", req_addr); end
    endtask

    task automatic test_fetch_seq();
        logic [31:0] v [3];
        logic [31:0] exp_a;
        v[0] = 32'h00000413; v[1] = 32'h00009117; v[2] = 32'hffc10113;
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'h80000000 + 32'(4 * i);
            checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL seq_req_valid[%0d]: got %b expected 1", i, req_valid); end
            checks++; if (req_addr !== exp_a) begin errors++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, req_addr, exp_a); end
            req_ready = 1; cyc(); req_ready = 0;
            checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL seq_wait[%0d]: got req_valid=%b inst_valid=%b expected 0 0", i, req_valid, inst_valid); end
            rsp_valid = 1; rsp_inst = v[i]; cyc(); rsp_valid = 0;
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_inst_valid[%0d]: got %b expected 1", i, inst_valid); end
            checks++; if (inst !== v[i]) begin errors++; $display("FAIL seq_inst[%0d]: got %h expected %h", i, inst, v[i]); end
            checks++; if (inst_pc !== exp_a) begin errors++; $display("FAIL seq_inst_pc[%0d]: got %h expected %h", i, inst_pc, exp_a); end
            inst_ready = 1; cyc(); inst_ready = 0;
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_consumed[%0d]: got inst_valid=%b expected 0", i, inst_valid); end
            checks++; if (pc !== exp_a + 32'd4) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_a + 32'd4); end
        end
        checks++; if (req_addr !== 32'h8000000c) begin errors++; $display("FAIL seq_next_addr: got %h expected 8000000c", req_addr); end
    endtask

    task automatic test_stall();
        apply_reset();
        cyc();
        for (int i = 0; i < 5; i++) begin
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000000) begin errors++; $display("FAIL stall[%0d]: got valid=%b addr=%h expected 1 80000000", i, req_valid, req_addr); end
            cyc();
        end
        req_ready = 1; cyc(); req_ready = 0;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL stall_one_req: got req_valid=%b expected 0", req_valid); end
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1; redirect_pc = 32'h80000100; cyc(); redirect_valid = 0;
        checks++; if (pc !== 32'h80000100) begin errors++; $display("FAIL rdw_pc: got %h expected 80000100", pc); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rdw_still_wait: got req_valid=%b expected 0", req_valid); end
        rsp_valid = 1; rsp_inst = 32'hdeadbeef; cyc(); rsp_valid = 0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped: got inst_valid=%b expected 0", inst_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000100) begin errors++; $display("FAIL rdw_next_req: got valid=%b addr=%h expected 1 80000100", req_valid, req_addr); end
        redirect_valid = 1; redirect_pc = 32'h80000300; cyc(); redirect_valid = 0;
        checks++; if (req_addr !== 32'h80000100) begin errors++; $display("FAIL rdq_addr_stable: got %h expected 80000100", req_addr); end
        checks++; if (pc !== 32'h80000300) begin errors++; $display("FAIL rdq_pc: got %h expected 80000300", pc); end
        fetch_to_hold(32'h12345678);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdq_dropped: got inst_valid=%b expected 0", inst_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000300) begin errors++; $display("FAIL rdq_next_req: got valid=%b addr=%h expected 1 80000300", req_valid, req_addr); end
    endtask

    task automatic test_trap_hold();
        fetch_to_hold(32'h00100093);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80000300) begin errors++; $display("FAIL trap_hold: got valid=%b inst_pc=%h expected 1 80000300", inst_valid, inst_pc); end
        trap_valid = 1; mtvec = 32'h80001000; redirect_valid = 1; redirect_pc = 32'h80000200; inst_ready = 1;
        cyc();
        clear_inputs();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL trap_consumed: got inst_valid=%b expected 0", inst_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80001000) begin errors++; $display("FAIL trap_priority: got valid=%b addr=%h expected 1 80001000", req_valid, req_addr); end
    endtask

    task automatic test_wrap_align();
        fetch_to_hold(32'h00000013);
        redirect_valid = 1; redirect_pc = 32'hfffffffc; inst_ready = 1; cyc(); clear_inputs();
        checks++; if (req_addr !== 32'hfffffffc) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", req_addr); end
        fetch_to_hold(32'h00000013);
        checks++; if (inst_pc !== 32'hfffffffc) begin errors++; $display("FAIL wrap_inst_pc: got %h expected fffffffc", inst_pc); end
        inst_ready = 1; cyc(); inst_ready = 0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h00000000) begin errors++; $display("FAIL wrap_addr: got valid=%b addr=%h expected 1 00000000", req_valid, req_addr); end
        fetch_to_hold(32'h00000013);
        redirect_valid = 1; redirect_pc = 32'h80000103; cyc(); redirect_valid = 0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL hold_redir_stays: got inst_valid=%b expected 1", inst_valid); end
        checks++; if (pc !== 32'h80000100) begin errors++; $display("FAIL align_pc: got %h expected 80000100", pc); end
        inst_ready = 1; cyc(); inst_ready = 0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000100) begin errors++; $display("FAIL align_req_addr: got valid=%b addr=%h expected 1 80000100", req_valid, req_addr); end
    endtask

    task automatic test_halt();
        apply_reset();
        cyc();
        req_ready = 1; cyc(); req_ready = 0;
        halt = 1; redirect_valid = 1; redirect_pc = 32'h80000600; cyc(); halt = 0; redirect_valid = 0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got halted=%b expected 0", halted); end
        rsp_valid = 1; rsp_inst = 32'h00100073; cyc(); rsp_valid = 0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_entered: got halted=%b expected 1", halted); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_dropped: got inst_valid=%b expected 0", inst_valid); end
        req_ready = 1; inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h80000700;
        repeat (3) cyc();
        clear_inputs();
        checks++; if (req_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_terminal: got req_valid=%b halted=%b expected 0 1", req_valid, halted); end
        checks++; if (pc !== 32'h80000600) begin errors++; $display("FAIL halt_pc: got %h expected 80000600", pc); end
        rst = 0; #2;
        checks++; if (halted !== 1'b0 || pc !== 32'h80000000) begin errors++; $display("FAIL halt_rst: got halted=%b pc=%h expected 0 80000000", halted, pc); end
        cyc(); rst = 1; cyc();
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000000) begin errors++; $display("FAIL halt_restart: got valid=%b addr=%h expected 1 80000000", req_valid, req_addr); end
    endtask

    task automatic test_reset_midflight();
        req_ready = 1; cyc(); req_ready = 0;
        rst = 0; #2;
        cyc();
        rst = 1; rsp_valid = 1; rsp_inst = 32'hcafebabe;
        cyc();
        cyc();
        rsp_valid = 0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ignored: got inst_valid=%b expected 0", inst_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000000) begin errors++; $display("FAIL mid_rst_req: got valid=%b addr=%h expected 1 80000000", req_valid, req_addr); end
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect_wait();
        test_trap_hold();
        test_wrap_align();
        test_halt();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
